// File: rtl/debounced_pio_pkg.sv
// Shared register map and bus types for the debounced input PIO.
package debounced_pio_pkg;

    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ADDR_DATA      = 3'd0;
    localparam addr_t ADDR_RISE_EN   = 3'd1;
    localparam addr_t ADDR_IRQ_MASK  = 3'd2;
    localparam addr_t ADDR_CAPTURE   = 3'd3;
    localparam addr_t ADDR_FALL_EN   = 3'd4;
    localparam addr_t ADDR_DB_THRESH = 3'd5;

endpackage

// File: rtl/debounced_pio_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface debounced_pio_if;
    import debounced_pio_pkg::*;

    addr_t       address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/debounced_pio_irq_debounce_channel.sv
// One input channel: synchroniser, tick-based stability counter,
// debounced state and edge pulses derived from it.
module debounce_channel #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_W        = 4,
    parameter logic IDLE        = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pin,
    input  logic            tick,
    input  logic [DB_W-1:0] thresh,
    output logic            state,
    output logic            rise,
    output logic            fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   prev;
    logic [DB_W-1:0]        cnt;
    logic [DB_W-1:0]        cnt_inc;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    // A zero threshold bypasses filtering; a counter already at or past a
    // lowered threshold commits on the next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            prev  <= IDLE;
            cnt   <= '0;
        end else begin
            prev <= state;
            if (thresh == '0) begin
                state <= sync;
                cnt   <= '0;
            end else if (sync == state) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt_inc >= thresh) begin
                    state <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    assign rise = state & ~prev;
    assign fall = ~state & prev;

endmodule

// File: rtl/debounced_pio_irq.sv
// Avalon-MM input PIO with per-channel debounce, edge capture and
// maskable level interrupt.
module debounced_pio_irq
    import debounced_pio_pkg::*;
#(
    parameter int               WIDTH       = 3,
    parameter int               SYNC_STAGES = 2,
    parameter int               TICK_DIV    = 50000,
    parameter int               DB_W        = 4,
    parameter int               DB_RESET    = 8,
    parameter logic [WIDTH-1:0] IDLE_LEVEL  = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    debounced_pio_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    presc;
    logic             tick;
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] clr;
    logic [DB_W-1:0]  thresh;
    logic [31:0]      rd_next;
    logic             unused;

    assign unused = ^bus.writedata;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W),
            .IDLE        (IDLE_LEVEL[i])
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .tick    (tick),
            .thresh  (thresh),
            .state   (state[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign wr  = bus.chipselect & ~bus.write_n;
    assign wd  = bus.writedata[WIDTH-1:0];
    assign hit = (rise & rise_en) | (fall & fall_en);
    assign clr = (wr && bus.address == ADDR_CAPTURE) ? wd : '0;

    // A new edge in the same cycle as its clear must survive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en <= '0;
            fall_en <= '1;
            mask    <= '0;
            thresh  <= DB_W'(DB_RESET);
            capture <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.address)
                    ADDR_RISE_EN:   rise_en <= wd;
                    ADDR_IRQ_MASK:  mask    <= wd;
                    ADDR_FALL_EN:   fall_en <= wd;
                    ADDR_DB_THRESH: thresh  <= bus.writedata[DB_W-1:0];
                    default: ;
                endcase
            end
            capture <= (capture & ~clr) | hit;
            irq     <= |(capture & mask);
        end
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:      rd_next = 32'(state);
            ADDR_RISE_EN:   rd_next = 32'(rise_en);
            ADDR_IRQ_MASK:  rd_next = 32'(mask);
            ADDR_CAPTURE:   rd_next = 32'(capture);
            ADDR_FALL_EN:   rd_next = 32'(fall_en);
            ADDR_DB_THRESH: rd_next = 32'(thresh);
            default:        rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
        end
    end

endmodule
